// File: rtl/dice_pkg.sv
// ============================================================================
// Module  : dice_pkg
// Brief   : Shared constants, state encoding and 7-segment decode for the dice core.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package dice_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ROLL = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    // Segment bit 0 is 'a', bit 6 is 'g'
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [83:0] SIDES_BCD_DEFAULT = {
        12'h100, 12'h020, 12'h012, 12'h010, 12'h008, 12'h006, 12'h004
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_OFF;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_down_counter.sv
// ============================================================================
// Module  : bcd_down_counter
// Brief   : Multi-digit BCD down counter with load and wrap-at-one.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_down_counter #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  dec,
    input  logic [4*DIGITS-1:0]   wrap_val,
    output logic [4*DIGITS-1:0]   q
);

    localparam int              VW      = 4 * DIGITS;
    localparam logic [VW-1:0]   ONE_VAL = {{(VW-1){1'b0}}, 1'b1};

    logic [VW-1:0] dec_val;

    // Ripple borrow: a zero digit becomes 9 and passes the borrow upward
    always_comb begin : p_dec
        logic borrow;
        borrow  = 1'b1;
        dec_val = q;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= ONE_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (dec) begin
            q <= (q == ONE_VAL) ? wrap_val : dec_val;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dice_roll_engine.sv
// ============================================================================
// Module  : dice_roll_engine
// Brief   : Button-driven BCD dice roller with multiplexed 7-segment display.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module dice_roll_engine
    import dice_pkg::*;
#(
    parameter int                          DIGITS        = 3,
    parameter int                          N_BTN         = 7,
    parameter logic [N_BTN*4*DIGITS-1:0]   SIDES_BCD     = SIDES_BCD_DEFAULT,
    parameter int                          TIMEOUT_TICKS = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [N_BTN-1:0]      btn,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_en,
    output logic [4*DIGITS-1:0]   result_bcd,
    output logic                  result_valid,
    output logic                  rolling
);

    localparam int              VW           = 4 * DIGITS;
    localparam int              SW           = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int              DW           = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam logic [VW-1:0]   RESULT_RST   = {{(VW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]   S_LAST       = SW'(DIGITS - 1);
    localparam logic [7:0]      TIMEOUT_INIT = 8'(TIMEOUT_TICKS);

    state_t            state;
    state_t            state_next;
    logic [DW-1:0]     die;
    logic [DW-1:0]     press_idx;
    logic [VW-1:0]     value;
    logic [7:0]        timeout;
    logic [SW-1:0]     s;
    logic [DIGITS-1:0] lit;
    logic [DIGITS-1:0] onehot;
    logic [VW-1:0]     sides [N_BTN];
    logic              any_btn;
    logic              held;
    logic              start;
    logic              dec;
    logic              capture;
    logic              tick_dec;
    logic              disp_on;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_sides
        assign sides[gi] = SIDES_BCD[gi*VW +: VW];
    end

    // A digit stays lit while it or any more significant digit is non-zero
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lit
        if (gi == 0) begin : g_lsd
            assign lit[gi] = 1'b1;
        end else begin : g_upper
            assign lit[gi] = |result_bcd[VW-1:4*gi];
        end
    end

    assign any_btn = |btn;
    assign held    = btn[die];
    assign rolling = (state == ST_ROLL);

    always_comb begin
        press_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (btn[i]) press_idx = DW'(i);
        end
    end

    always_comb begin
        onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            onehot[i] = (s == SW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_OFF;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_OFF:  if (any_btn) state_next = ST_ROLL;
            ST_ROLL: if (!held)   state_next = ST_SHOW;
            ST_SHOW: begin
                if (any_btn)                        state_next = ST_ROLL;
                else if (tick && timeout == 8'd1)   state_next = ST_OFF;
            end
            default: state_next = ST_OFF;
        endcase
    end

    always_comb begin
        start    = (state == ST_OFF || state == ST_SHOW) && any_btn;
        dec      = (state == ST_ROLL) && held;
        capture  = (state == ST_ROLL) && !held;
        tick_dec = (state == ST_SHOW) && !any_btn && tick;
        // Going dark on the expiring tick itself keeps the turn-off one cycle after it
        disp_on  = (state == ST_SHOW) && (state_next == ST_SHOW);
    end

    bcd_down_counter #(
        .DIGITS (DIGITS)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .load_val (sides[press_idx]),
        .dec      (dec),
        .wrap_val (sides[die]),
        .q        (value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            die          <= '0;
            result_bcd   <= RESULT_RST;
            result_valid <= 1'b0;
            timeout      <= 8'd0;
            s            <= '0;
            seg          <= SEG_OFF;
            digit_en     <= '0;
        end else begin
            result_valid <= capture;
            if (start) die <= press_idx;
            if (capture) begin
                result_bcd <= value;
                timeout    <= TIMEOUT_INIT;
            end else if (tick_dec) begin
                timeout    <= timeout - 8'd1;
            end
            s <= (s == S_LAST) ? '0 : s + SW'(1);
            if (disp_on && lit[s]) begin
                seg      <= seg_decode(result_bcd[4*s +: 4]);
                digit_en <= onehot;
            end else begin
                seg      <= SEG_OFF;
                digit_en <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dice_roll_engine.sv
// ============================================================================
// Module  : tb_dice_roll_engine
// Brief   : Directed self-checking bench for dice_roll_engine.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dice_roll_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [6:0]  btn;
    logic [6:0]  seg;
    logic [2:0]  digit_en;
    logic [11:0] result_bcd;
    logic        result_valid;
    logic        rolling;

    int errors    = 0;
    int checks    = 0;
    int valid_cnt = 0;
    int v0;

    logic [2:0]  lit_mask;
    logic [6:0]  seg_seen [3];

    always #5 clk = ~clk;

    dice_roll_engine #(
        .DIGITS        (3),
        .N_BTN         (7),
        .SIDES_BCD     ({12'h100, 12'h020, 12'h012, 12'h010, 12'h008, 12'h006, 12'h004}),
        .TIMEOUT_TICKS (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .btn          (btn),
        .seg          (seg),
        .digit_en     (digit_en),
        .result_bcd   (result_bcd),
        .result_valid (result_valid),
        .rolling      (rolling)
    );

    always @(posedge clk) if (result_valid) valid_cnt <= valid_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic [6:0] b, input int n);
        btn = b;
        step(n);
        btn = '0;
    endtask

    task automatic pulse_tick;
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic scan3;
        lit_mask = '0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            for (int j = 0; j < 3; j++) begin
                if (digit_en[j]) begin
                    lit_mask[j] = 1'b1;
                    seg_seen[j] = seg;
                end
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        btn  = '0;
        for (int i = 0; i < 3; i++) seg_seen[i] = '0;
        step(3);
        check("rst_rolling",  32'(rolling),      32'h0);
        check("rst_result",   32'(result_bcd),   32'h001);
        check("rst_valid",    32'(result_valid), 32'h0);
        check("rst_seg",      32'(seg),          32'h0);
        check("rst_digit_en", 32'(digit_en),     32'h0);
        rst = 1'b0;
        step(1);

        // d6 held 10 cycles -> 3
        v0  = valid_cnt;
        btn = 7'b0000010;
        step(1);
        check("d6_rolling", 32'(rolling), 32'h1);
        step(9);
        btn = '0;
        step(1);
        check("d6_valid",   32'(result_valid), 32'h1);
        check("d6_result",  32'(result_bcd),   32'h003);
        check("d6_rolling_off", 32'(rolling),  32'h0);
        scan3();
        check("d6_one_pulse", 32'(valid_cnt - v0), 32'h1);
        check("d6_lit_mask",  32'(lit_mask),       32'h1);
        check("d6_seg0",      32'(seg_seen[0]),    32'h4F);

        // d100 held 101 cycles -> 100, all digits lit
        hold(7'b1000000, 101);
        step(1);
        check("d100_valid",  32'(result_valid), 32'h1);
        check("d100_result", 32'(result_bcd),   32'h100);
        scan3();
        check("d100_lit_mask", 32'(lit_mask),    32'h7);
        check("d100_seg2",     32'(seg_seen[2]), 32'h06);
        check("d100_seg1",     32'(seg_seen[1]), 32'h3F);
        check("d100_seg0",     32'(seg_seen[0]), 32'h3F);

        // Timeout after 3 ticks
        pulse_tick();
        pulse_tick();
        scan3();
        check("to_lit_before", 32'(lit_mask), 32'h7);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        check("to_digit_en", 32'(digit_en), 32'h0);
        check("to_seg",      32'(seg),      32'h0);
        scan3();
        check("to_dark",     32'(lit_mask),   32'h0);
        check("to_retained", 32'(result_bcd), 32'h100);

        // btn[2] and btn[5] together for 4 cycles -> d8 wins, 5
        hold(7'b0100100, 4);
        step(1);
        check("d8_valid",  32'(result_valid), 32'h1);
        check("d8_result", 32'(result_bcd),   32'h005);

        // Re-roll from SHOW with d4 after partial timeout; timeout must restart
        pulse_tick();
        pulse_tick();
        hold(7'b0000001, 3);
        step(1);
        check("d4_valid",  32'(result_valid), 32'h1);
        check("d4_result", 32'(result_bcd),   32'h002);
        pulse_tick();
        pulse_tick();
        scan3();
        check("d4_lit_after_2_ticks", 32'(lit_mask),    32'h1);
        check("d4_seg0",              32'(seg_seen[0]), 32'h5B);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        check("d4_to_digit_en", 32'(digit_en), 32'h0);
        scan3();
        check("d4_to_dark", 32'(lit_mask), 32'h0);

        // Reset mid-roll
        v0  = valid_cnt;
        btn = 7'b1000000;
        step(5);
        check("mid_rolling", 32'(rolling), 32'h1);
        rst = 1'b1;
        btn = '0;
        step(1);
        check("mid_rst_rolling",  32'(rolling),      32'h0);
        check("mid_rst_result",   32'(result_bcd),   32'h001);
        check("mid_rst_valid",    32'(result_valid), 32'h0);
        check("mid_rst_seg",      32'(seg),          32'h0);
        check("mid_rst_digit_en", 32'(digit_en),     32'h0);
        rst = 1'b0;
        step(3);
        check("mid_rst_no_pulse", 32'(valid_cnt - v0), 32'h0);
        check("mid_rst_idle",     32'(rolling),        32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dice_roll_engine.md
# dice_roll_engine

Parametrised dice-roll core for the TTRPG dice project. It takes debounced per-die buttons and runs an N-digit BCD roll counter for the selected die, wrapping at that die's side count. It time-multiplexes the result onto a 7-segment bus with leading-zero blanking and a tick-based display timeout. It sits between the button debouncers and the top-level polarity-inversion logic, and generalises the two-digit, fixed-die roller to any digit count, button count and die-size table.

## Interface

Parameters:
- `DIGITS`, 3: BCD digits in the roll counter and on the display.
- `N_BTN`, 7: number of die buttons.
- `SIDES_BCD`, {12'h100,12'h020,12'h012,12'h010,12'h008,12'h006,12'h004}: flattened `N_BTN*4*DIGITS`. Slice i is the BCD side count of button i. Every slice must be ≥ 1.
- `TIMEOUT_TICKS`, 255: display-on time in `tick` periods. Range 1..255.

Ports:
- `clk`  in  1  — single clock, all logic on posedge.
- `rst`  in  1  — synchronous, active-high reset.
- `tick`  in  1  — one-cycle timeout strobe (e.g. 32 Hz).
- `btn`  in  N_BTN  — debounced, active-high die buttons.
- `seg`  out  7  — segments a..g, active-high, registered.
- `digit_en`  out  DIGITS  — one-hot digit common, active-high, registered. Bit 0 is the least significant digit.
- `result_bcd`  out  4*DIGITS  — last completed roll, held until the next roll completes.
- `result_valid`  out  1  — one-cycle pulse when `result_bcd` updates.
- `rolling`  out  1  — high while in ROLL.

## Operation

- States: OFF, ROLL, SHOW.
- OFF → ROLL: on the first cycle with `|btn` true.
  - Latch `die` = lowest set index of `btn`.
  - Load `value` with `SIDES_BCD[die]`.
- ROLL, each later cycle with `btn[die]` high: `value` decrements in BCD with per-digit borrow.
  - 1 wraps to `SIDES_BCD[die]`.
  - `value` never reaches 0.
- ROLL → SHOW: on the first cycle with `btn[die]` low.
  - `result_bcd` <= `value`, `result_valid` pulses.
  - Timeout counter <= `TIMEOUT_TICKS`.
  - Other buttons pressed during ROLL are ignored.
- SHOW:
  - The timeout counter decrements on each `tick`. At 0, go to OFF.
  - Any `|btn` in SHOW behaves as OFF → ROLL (re-roll, new die latched).
- Display:
  - Scan index `s` increments every cycle, modulo `DIGITS`.
  - In SHOW, `digit_en` = one-hot(s) and `seg` = decode(`result_bcd` digit s).
  - Leading-zero blanking: digit s>0 is blanked (`digit_en` = 0) if it and all higher digits are 0. Digit 0 is never blanked.
  - In OFF and ROLL: `digit_en` = 0 and `seg` = 0.
  - Decode: 0-9 standard; A-F codes decode to all-off.
- Reset values: state OFF, `value` = 1, `die` = 0, `result_bcd` = 1, `result_valid` = 0, `rolling` = 0, `seg` = 0, `digit_en` = 0, timeout = 0, `s` = 0.

## Timing

- Press first seen at cycle t:
  - `rolling` = 1 at t+1.
  - `value` = max at t+1, then one decrement per cycle while held.
  - Button high for N cycles gives `result_bcd` = max − ((N−1) mod max).
- Release first seen at cycle r: `result_valid` and new `result_bcd` at r+1, state SHOW at r+1.
- `seg`/`digit_en` lag the scan index by one cycle. The first lit digit appears at r+2.
- `tick` coincident with entry to SHOW is ignored. Display-off occurs on the `TIMEOUT_TICKS`-th subsequent tick (+1 cycle).
- Simultaneous press of several buttons: lowest index wins.
- `rst` mid-roll: next cycle is fully at reset values, with no `result_valid`.

## Structure

- Shared package `dice_pkg` holds:
  - the 7-segment digit constants (`SEG_0`..`SEG_9`, `SEG_OFF`);
  - the state encoding;
  - the default `SIDES_BCD` constant.
- Sub-module `bcd_down_counter`: parameter `DIGITS`.
  - Ports: `load`, `load_val`, `dec`, `wrap_val`, `q`.
  - Wrap is applied when `q` == 1 and `dec` is high.
- Top module holds the FSM, timeout, scan and decode.

## Test plan

- Defaults. `btn[1]` (d6) high for exactly 10 cycles → `result_bcd` = 12'h003, one `result_valid` pulse. Display shows "3" on digit 0 only; digits 1 and 2 are blanked.
- `btn[6]` (d100) held 101 cycles → `result_bcd` = 12'h100. All three digits lit: `seg` = 1,0,0 across the scan.
- `btn[2]` and `btn[5]` asserted in the same cycle, then released together after 4 cycles → die d8, `result_bcd` = 12'h005.
- `TIMEOUT_TICKS` = 3. After a roll, 3 `tick` pulses → `digit_en` = 0 one cycle after the third tick. `result_bcd` is retained.
- `rst` asserted while `rolling` = 1 → next cycle `rolling` = 0, `result_bcd` = 12'h001, no `result_valid`. Outputs are dark.
- In SHOW, press `btn[0]` (d4) for 3 cycles → re-roll with `result_bcd` = 12'h002. Timeout restarts from `TIMEOUT_TICKS`.
